// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access stage: data bus records, pipeline bundles,
// the load/store op encoding and the helpers that decode it.
package memory_access_pkg;

  localparam int XLEN     = 64;
  localparam int MMIO_BIT = 31;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ALU, OP_BRANCH,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} ma_state_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    op_t             op;
    logic [31:0]     inst;
    logic [63:0]     inst_pc;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] rs2_data;
    logic            valid;
    logic            jump;
    logic            difftest_skip;
    logic [63:0]     inst_counter;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] value;
    logic [31:0]     inst;
    logic [63:0]     inst_pc;
    op_t             op;
    logic            valid;
    logic            jump;
    logic            difftest_skip;
    logic [63:0]     inst_counter;
  } mem_wb_t;

  typedef struct packed {
    logic            reg_write_enable;
    logic [4:0]      reg_dest_addr;
    logic [XLEN-1:0] reg_write_data;
  } reg_writer_t;

  function automatic logic op_is_load(op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic op_is_store(op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic op_writes_reg(op_t op);
    return !(op_is_store(op) || op == OP_NOP || op == OP_BRANCH);
  endfunction

  function automatic msize_t op_size(op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return MSIZE1;
      OP_LH, OP_LHU, OP_SH: return MSIZE2;
      OP_LW, OP_LWU, OP_SW: return MSIZE4;
      default:              return MSIZE8;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data bus between the memory-access stage (master) and the memory system (slave).
interface memory_access_if;
  import memory_access_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/memory_access_mem_align.sv
// Byte-lane alignment: access size, misalignment, store strobe/data placement
// and load extraction with sign/zero extension.
module memory_access_mem_align
  import memory_access_pkg::*;
(
  input  op_t             op_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [63:0]     rdata_i,
  output msize_t          size_o,
  output logic            misaligned_o,
  output logic [7:0]      strobe_o,
  output logic [63:0]     wdata_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [5:0]  bit_off;
  logic [63:0] shifted;
  logic [7:0]  lane_mask;
  logic [2:0]  size_mask;

  assign size_o  = op_size(op_i);
  assign bit_off = {addr_lo_i, 3'b000};

  always_comb begin
    lane_mask = 8'hff;
    size_mask = 3'b111;
    case (size_o)
      MSIZE1: begin lane_mask = 8'h01; size_mask = 3'b000; end
      MSIZE2: begin lane_mask = 8'h03; size_mask = 3'b001; end
      MSIZE4: begin lane_mask = 8'h0f; size_mask = 3'b011; end
      default: ;
    endcase
  end

  assign misaligned_o = |(addr_lo_i & size_mask);
  assign strobe_o     = lane_mask << addr_lo_i;
  assign wdata_o      = rs2_data_i << bit_off;
  assign shifted      = rdata_i >> bit_off;

  always_comb begin
    load_data_o = shifted;
    case (op_i)
      OP_LB:   load_data_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      OP_LH:   load_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      OP_LW:   load_data_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      OP_LBU:  load_data_o = {{(XLEN-8){1'b0}},  shifted[7:0]};
      OP_LHU:  load_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      OP_LWU:  load_data_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues one data-bus transaction per load/store,
// stalls via ok_o while it is outstanding, and builds the writeback bundle.
module memory_access
  import memory_access_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  ex_mem_t         ex_mem_state_i,
  input  logic            advance_i,
  input  logic            flush_i,
  memory_access_if.master dbus,
  output mem_wb_t         mem_wb_state_o,
  output reg_writer_t     forward_o,
  output logic            ok_o
);

  // state  | meaning
  // S_IDLE | no transaction; a valid aligned mem op issues dreq combinationally
  // S_REQ  | request held on the bus until data_ok
  // S_DONE | response latched, result final until advance or flush

  ma_state_e       state_q, state_d;
  dbus_req_t       req_q, req_d, new_req;
  logic [63:0]     rdata_q, rdata_d;
  logic            aborted_q, aborted_d;

  msize_t          size;
  logic            misaligned;
  logic [7:0]      strobe;
  logic [63:0]     wdata;
  logic [XLEN-1:0] load_data;
  logic            is_load, is_store, is_mem, issue, wb_valid;

  memory_access_mem_align u_align (
    .op_i         (ex_mem_state_i.op),
    .addr_lo_i    (ex_mem_state_i.value[2:0]),
    .rs2_data_i   (ex_mem_state_i.rs2_data),
    .rdata_i      (rdata_q),
    .size_o       (size),
    .misaligned_o (misaligned),
    .strobe_o     (strobe),
    .wdata_o      (wdata),
    .load_data_o  (load_data)
  );

  assign is_load  = ex_mem_state_i.valid && op_is_load(ex_mem_state_i.op);
  assign is_store = ex_mem_state_i.valid && op_is_store(ex_mem_state_i.op);
  assign is_mem   = is_load || is_store;
  // Gating with rst_n keeps dreq quiet while reset is held.
  assign issue    = rst_n && is_mem && !misaligned && !flush_i;

  always_comb begin
    new_req       = '0;
    new_req.valid = 1'b1;
    new_req.addr  = ex_mem_state_i.value;
    new_req.size  = size;
    if (is_store) begin
      new_req.strobe = strobe;
      new_req.data   = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      rdata_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    aborted_d = aborted_q;
    dbus.dreq = '0;
    ok_o      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          dbus.dreq = new_req;
          req_d     = new_req;
          aborted_d = 1'b0;
          ok_o      = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // A flushed request still runs to completion; only its result is dropped.
        dbus.dreq = req_q;
        ok_o      = 1'b0;
        if (flush_i) aborted_d = 1'b1;
        if (dbus.dresp.data_ok) begin
          rdata_d   = dbus.dresp.data;
          aborted_d = 1'b0;
          state_d   = (flush_i || aborted_q) ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        if (advance_i || flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_valid = ex_mem_state_i.valid && !flush_i && !(state_q == S_REQ && aborted_q);

  always_comb begin
    mem_wb_state_o              = '0;
    mem_wb_state_o.inst         = ex_mem_state_i.inst;
    mem_wb_state_o.inst_pc      = ex_mem_state_i.inst_pc;
    mem_wb_state_o.op           = ex_mem_state_i.op;
    mem_wb_state_o.valid        = wb_valid;
    mem_wb_state_o.jump         = ex_mem_state_i.jump;
    mem_wb_state_o.inst_counter = ex_mem_state_i.inst_counter;
    mem_wb_state_o.difftest_skip = ex_mem_state_i.difftest_skip ||
        (is_mem && (misaligned || !ex_mem_state_i.value[MMIO_BIT]));
    if (is_load) mem_wb_state_o.value = misaligned ? '0 : load_data;
    else         mem_wb_state_o.value = ex_mem_state_i.value;
  end

  always_comb begin
    forward_o                  = '0;
    forward_o.reg_write_enable = op_writes_reg(ex_mem_state_i.op) && wb_valid && ok_o;
    forward_o.reg_dest_addr    = ex_mem_state_i.inst[11:7];
    forward_o.reg_write_data   = mem_wb_state_o.value;
  end

endmodule
